// File: rtl/guess_entry_ctrl.sv
// Wordle round front end: assembles a 5-letter guess with backspace, hands the
// packed word to the combinational colour checker, captures its green/yellow
// result, counts attempts and latches win/lose until a new game is requested.
module guess_entry_ctrl #(
    parameter int unsigned NUM_LETTERS = 5,
    parameter int unsigned LETTER_W    = 5,
    parameter int unsigned MAX_GUESSES = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            new_game,
    input  logic                            letter_valid,
    input  logic [LETTER_W-1:0]             letter_code,
    input  logic                            backspace,
    input  logic                            submit,
    output logic [NUM_LETTERS*LETTER_W-1:0] guess_word,
    input  logic [NUM_LETTERS-1:0]          greens_in,
    input  logic [NUM_LETTERS-1:0]          yellows_in,
    output logic [2:0]                      cursor,
    output logic [2:0]                      guess_count,
    output logic [NUM_LETTERS-1:0]          result_greens,
    output logic [NUM_LETTERS-1:0]          result_yellows,
    output logic                            result_valid,
    output logic                            win,
    output logic                            lose
);

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0]          FULL     = 3'(NUM_LETTERS);
    localparam logic [2:0]          MAXG     = 3'(MAX_GUESSES);
    localparam logic [LETTER_W-1:0] MAX_CODE = LETTER_W'(25);

    state_t                            state, state_n;
    logic [NUM_LETTERS*LETTER_W-1:0]   word_n;
    logic [2:0]                        cursor_n, count_n;
    logic [NUM_LETTERS-1:0]            rg_n, ry_n;
    logic                              rv_n, win_n, lose_n;

    // Next-state and next-value logic; new_game overrides everything, and within
    // ENTRY only the highest-priority input is acted on each cycle.
    always_comb begin
        state_n  = state;
        word_n   = guess_word;
        cursor_n = cursor;
        count_n  = guess_count;
        rg_n     = result_greens;
        ry_n     = result_yellows;
        rv_n     = 1'b0;
        win_n    = win;
        lose_n   = lose;

        if (new_game) begin
            state_n  = ENTRY;
            word_n   = '0;
            cursor_n = '0;
            count_n  = '0;
            rg_n     = '0;
            ry_n     = '0;
            win_n    = 1'b0;
            lose_n   = 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    if (backspace) begin
                        if (cursor != '0) begin
                            cursor_n = cursor - 3'd1;
                            for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
                                if (i + 1 == 32'(cursor)) begin
                                    word_n[i*LETTER_W +: LETTER_W] = '0;
                                end
                            end
                        end
                    end else if (submit) begin
                        if (cursor == FULL) begin
                            state_n = CHECK;
                        end
                    end else if (letter_valid) begin
                        if (letter_code <= MAX_CODE && cursor < FULL) begin
                            cursor_n = cursor + 3'd1;
                            for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
                                if (i == 32'(cursor)) begin
                                    word_n[i*LETTER_W +: LETTER_W] = letter_code;
                                end
                            end
                        end
                    end
                end
                CHECK: begin
                    rg_n    = greens_in;
                    ry_n    = yellows_in;
                    rv_n    = 1'b1;
                    count_n = (guess_count < MAXG) ? guess_count + 3'd1 : guess_count;
                    if (greens_in == '1) begin
                        win_n   = 1'b1;
                        state_n = DONE;
                    end else if (guess_count + 3'd1 >= MAXG) begin
                        lose_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        word_n   = '0;
                        cursor_n = '0;
                        state_n  = ENTRY;
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = ENTRY;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ENTRY;
            guess_word     <= '0;
            cursor         <= '0;
            guess_count    <= '0;
            result_greens  <= '0;
            result_yellows <= '0;
            result_valid   <= 1'b0;
            win            <= 1'b0;
            lose           <= 1'b0;
        end else begin
            state          <= state_n;
            guess_word     <= word_n;
            cursor         <= cursor_n;
            guess_count    <= count_n;
            result_greens  <= rg_n;
            result_yellows <= ry_n;
            result_valid   <= rv_n;
            win            <= win_n;
            lose           <= lose_n;
        end
    end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl: stimulus pushes expected check results
// into a queue, a negedge monitor pops one per result_valid pulse.
module tb_guess_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic        letter_valid = 1'b0;
    logic [4:0]  letter_code = '0;
    logic        backspace = 1'b0;
    logic        submit = 1'b0;
    logic [24:0] guess_word;
    logic [4:0]  greens_in = '0;
    logic [4:0]  yellows_in = '0;
    logic [2:0]  cursor;
    logic [2:0]  guess_count;
    logic [4:0]  result_greens;
    logic [4:0]  result_yellows;
    logic        result_valid;
    logic        win;
    logic        lose;

    guess_entry_ctrl #(
        .NUM_LETTERS(5),
        .LETTER_W   (5),
        .MAX_GUESSES(6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_game      (new_game),
        .letter_valid  (letter_valid),
        .letter_code   (letter_code),
        .backspace     (backspace),
        .submit        (submit),
        .guess_word    (guess_word),
        .greens_in     (greens_in),
        .yellows_in    (yellows_in),
        .cursor        (cursor),
        .guess_count   (guess_count),
        .result_greens (result_greens),
        .result_yellows(result_yellows),
        .result_valid  (result_valid),
        .win           (win),
        .lose          (lose)
    );

    typedef struct {
        logic [4:0] g;
        logic [4:0] y;
        logic [2:0] cnt;
        logic       w;
        logic       l;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to check result latency.
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("res_greens",  32'(result_greens),  32'(e.g));
                check("res_yellows", 32'(result_yellows), 32'(e.y));
                check("res_count",   32'(guess_count),    32'(e.cnt));
                check("res_win",     32'(win),            32'(e.w));
                check("res_lose",    32'(lose),           32'(e.l));
                check("res_latency", 32'(cyc),            32'(e.cyc));
            end
        end
    end

    task automatic drive(input logic ng, input logic lv, input logic [4:0] code,
                         input logic bs, input logic sb);
        new_game = ng; letter_valid = lv; letter_code = code; backspace = bs; submit = sb;
        @(posedge clk); #1;
        new_game = 1'b0; letter_valid = 1'b0; backspace = 1'b0; submit = 1'b0;
    endtask

    task automatic letter(input logic [4:0] code);
        drive(1'b0, 1'b1, code, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic submit_expect(input logic [4:0] g, input logic [4:0] y,
                                 input logic [2:0] cnt, input logic w, input logic l);
        greens_in = g; yellows_in = y;
        q.push_back('{g: g, y: y, cnt: cnt, w: w, l: l, cyc: cyc + 2});
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_word"},   32'(guess_word),     0);
        check({tag, "_cursor"}, 32'(cursor),         0);
        check({tag, "_count"},  32'(guess_count),    0);
        check({tag, "_rg"},     32'(result_greens),  0);
        check({tag, "_ry"},     32'(result_yellows), 0);
        check({tag, "_rv"},     32'(result_valid),   0);
        check({tag, "_win"},    32'(win),            0);
        check({tag, "_lose"},   32'(lose),           0);
    endtask

    logic [24:0] w;

    initial begin
        // Reset state
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // 1: HELLO, all green -> win
        letter(5'd7); letter(5'd4); letter(5'd11); letter(5'd11); letter(5'd14);
        w = {5'd14, 5'd11, 5'd11, 5'd4, 5'd7};
        check("t1_cursor", 32'(cursor), 5);
        check("t1_word", 32'(guess_word), 32'(w));
        submit_expect(5'b11111, 5'b00000, 3'd1, 1'b1, 1'b0);
        idle(1);
        check("t1_win", 32'(win), 1);
        check("t1_lose", 32'(lose), 0);
        check("t1_count", 32'(guess_count), 1);
        check("t1_word_held", 32'(guess_word), 32'(w));
        // DONE ignores letters/backspace/submit
        letter(5'd3);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(3);
        check("t1_done_word", 32'(guess_word), 32'(w));
        check("t1_done_cursor", 32'(cursor), 5);
        // 5: new_game in DONE
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        check_zero("t5_newgame");

        // 2: submit with 3 letters ignored; 6th letter ignored
        letter(5'd1); letter(5'd2); letter(5'd3);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(3);
        check("t2_cursor_after_submit", 32'(cursor), 3);
        check("t2_count_after_submit", 32'(guess_count), 0);
        letter(5'd4); letter(5'd5);
        w = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
        letter(5'd9);
        check("t2_6th_word", 32'(guess_word), 32'(w));
        check("t2_6th_cursor", 32'(cursor), 5);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

        // 3: backspace sequence
        letter(5'd0); letter(5'd1); letter(5'd2);
        check("t3_word3", 32'(guess_word), 2080);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("t3_bs1_cursor", 32'(cursor), 2);
        check("t3_bs1_word", 32'(guess_word), 32);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("t3_bs2_cursor", 32'(cursor), 1);
        check("t3_bs2_word", 32'(guess_word), 0);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("t3_bs3_cursor", 32'(cursor), 0);
        drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        check("t3_bs4_cursor", 32'(cursor), 0);
        letter(5'd5);
        check("t3_one_letter", 32'(guess_word), 5);
        drive(1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
        check("t3_letter_bs_cursor", 32'(cursor), 0);
        check("t3_letter_bs_word", 32'(guess_word), 0);

        // 5: invalid code ignored
        letter(5'd27);
        check("t5_bad_code_cursor", 32'(cursor), 0);
        check("t5_bad_code_word", 32'(guess_word), 0);

        // 4: six misses -> lose
        for (int g = 0; g < 6; g++) begin
            w = '0;
            for (int i = 0; i < 5; i++) begin
                letter(5'(g + i));
                w[i*5 +: 5] = 5'(g + i);
            end
            check("t4_word", 32'(guess_word), 32'(w));
            submit_expect(5'b00100, 5'b01000, 3'(g + 1), 1'b0, (g == 5));
            idle(1);
            if (g < 5) begin
                check("t4_cleared_cursor", 32'(cursor), 0);
                check("t4_cleared_word", 32'(guess_word), 0);
                check("t4_lose_low", 32'(lose), 0);
            end
        end
        check("t4_lose", 32'(lose), 1);
        check("t4_win", 32'(win), 0);
        check("t4_count", 32'(guess_count), 6);
        letter(5'd1);
        check("t4_after_lose_word", 32'(guess_word), 32'(w));
        check("t4_after_lose_cursor", 32'(cursor), 5);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        check_zero("t4_newgame");

        // new_game during CHECK: no capture, no pulse
        for (int i = 0; i < 5; i++) letter(5'(i + 10));
        greens_in = 5'b11111;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(3);
        check_zero("ng_in_check");

        // 6: async reset mid-CHECK
        for (int i = 0; i < 5; i++) letter(5'(i + 3));
        greens_in = 5'b00001;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_word", 32'(guess_word), 0);
        check("t6_async_cursor", 32'(cursor), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(4);
        check_zero("t6_after_release");

        check("scoreboard_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
